// File: rtl/transpose_tile_scheduler_if.sv
// Control bus between the tile scheduler and the transpose-convolution tile.
// Optional perf counter signals exist only when TRANSPOSE_SCHED_PERF_EN is defined.
interface transpose_tile_scheduler_if #(
  parameter int NUM_BRAMS = 16,
  parameter int W_ADDR_W  = 10,
  parameter int I_ADDR_W  = 10,
  parameter int CNT_W     = 14
);
  // Tile request and backpressure
  logic                          start;
  logic [CNT_W-1:0]              num_ifmap;
  logic [W_ADDR_W-1:0]           w_base;
  logic [I_ADDR_W-1:0]           if_base;
  logic                          stall;
  // BRAM read side
  logic [NUM_BRAMS-1:0]          w_re;
  logic [NUM_BRAMS*W_ADDR_W-1:0] w_addr_rd_flat;
  logic [NUM_BRAMS-1:0]          if_re;
  logic [NUM_BRAMS*I_ADDR_W-1:0] if_addr_rd_flat;
  logic [3:0]                    ifmap_sel;
  // Transpose engine controls
  logic [NUM_BRAMS-1:0]          en_weight_load;
  logic [NUM_BRAMS-1:0]          en_ifmap_load;
  logic [NUM_BRAMS-1:0]          en_psum;
  logic [NUM_BRAMS-1:0]          clear_psum;
  logic [NUM_BRAMS-1:0]          en_output;
  logic [NUM_BRAMS-1:0]          ifmap_sel_ctrl;
  logic [4:0]                    done_select;
  // Status
  logic                          busy;
  logic                          done;
`ifdef TRANSPOSE_SCHED_PERF_EN
  logic [31:0]                   perf_busy_cycles;
  logic [31:0]                   perf_stall_cycles;
`endif

  // Scheduler side
  modport slave (
    input  start, num_ifmap, w_base, if_base, stall,
    output w_re, w_addr_rd_flat, if_re, if_addr_rd_flat, ifmap_sel,
           en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output,
           ifmap_sel_ctrl, done_select, busy, done
`ifdef TRANSPOSE_SCHED_PERF_EN
    , output perf_busy_cycles, perf_stall_cycles
`endif
  );

  // Requester / observer side
  modport master (
    output start, num_ifmap, w_base, if_base, stall,
    input  w_re, w_addr_rd_flat, if_re, if_addr_rd_flat, ifmap_sel,
           en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output,
           ifmap_sel_ctrl, done_select, busy, done
`ifdef TRANSPOSE_SCHED_PERF_EN
    , input perf_busy_cycles, perf_stall_cycles
`endif
  );
endinterface

// File: rtl/transpose_tile_scheduler.sv
// Sequencer for the transpose-convolution compute tile: one weight row load,
// then per ifmap element fetch -> load/clear -> MAC -> 16-beat column drain.
// Optional macro TRANSPOSE_SCHED_PERF_EN adds busy/stall cycle counters.
module transpose_tile_scheduler #(
  parameter int NUM_BRAMS = 16,
  parameter int W_ADDR_W  = 10,
  parameter int I_ADDR_W  = 10,
  parameter int CNT_W     = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  transpose_tile_scheduler_if.slave     tif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_WLOAD, S_FETCH, S_LOAD, S_MAC, S_DRAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     k_q, k_d;
  logic [3:0]           j_q, j_d;
  logic [CNT_W-1:0]     num_q;
  logic [W_ADDR_W-1:0]  w_base_q;
  logic [I_ADDR_W-1:0]  if_base_q;

  // Held output values: each register keeps the last value its state drove
  logic [W_ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [I_ADDR_W-1:0]  if_addr_q, if_addr_d;
  logic [3:0]           sel_q, sel_d;
  logic [4:0]           dsel_q, dsel_d;

  // Strobes and status
  logic [NUM_BRAMS-1:0] w_re_s, if_re_s, ld_w_s, ld_if_s, psum_s, clr_s, out_s;
  logic                 busy_s, done_s;

  logic accept;
  logic stall_hon;

  assign accept    = (state_q == S_IDLE) && tif.start;
  // Only the BRAM-read and drain states may be held back
  assign stall_hon = tif.stall &&
                     ((state_q == S_WFETCH) || (state_q == S_FETCH) || (state_q == S_DRAIN));

  // State and loop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
    end
  end

  // Tile configuration captured on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q     <= '0;
      w_base_q  <= '0;
      if_base_q <= '0;
    end else if (accept) begin
      num_q     <= tif.num_ifmap;
      w_base_q  <= tif.w_base;
      if_base_q <= tif.if_base;
    end
  end

  // Address/select hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_q  <= '0;
      if_addr_q <= '0;
      sel_q     <= '0;
      dsel_q    <= '0;
    end else begin
      w_addr_q  <= w_addr_d;
      if_addr_q <= if_addr_d;
      sel_q     <= sel_d;
      dsel_q    <= dsel_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (tif.start) state_d = (tif.num_ifmap == '0) ? S_DONE : S_WFETCH;
      end
      S_WFETCH: begin
        if (!tif.stall) state_d = S_WLOAD;
      end
      S_WLOAD: begin
        state_d = S_FETCH;
        k_d     = '0;
      end
      S_FETCH: begin
        if (!tif.stall) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_MAC;
      S_MAC: begin
        state_d = S_DRAIN;
        j_d     = '0;
      end
      S_DRAIN: begin
        if (!tif.stall) begin
          if (j_q == 4'd15) begin
            if (k_q == num_q - CNT_W'(1)) begin
              state_d = S_DONE;
            end else begin
              k_d     = k_q + CNT_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            j_d = j_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; strobes are gated by an honoured stall, selects follow the held counters
  always_comb begin
    w_re_s    = '0;
    if_re_s   = '0;
    ld_w_s    = '0;
    ld_if_s   = '0;
    psum_s    = '0;
    clr_s     = '0;
    out_s     = '0;
    busy_s    = 1'b1;
    done_s    = 1'b0;
    w_addr_d  = w_addr_q;
    if_addr_d = if_addr_q;
    sel_d     = sel_q;
    dsel_d    = dsel_q;
    case (state_q)
      S_IDLE:   busy_s = 1'b0;
      S_WFETCH: begin
        w_addr_d = w_base_q;
        if (!tif.stall) w_re_s = '1;
      end
      S_WLOAD:  ld_w_s = '1;
      S_FETCH: begin
        sel_d     = k_q[3:0];
        // Row within the bank wraps silently at the address width
        if_addr_d = if_base_q + I_ADDR_W'(k_q >> 4);
        if (!tif.stall) if_re_s = NUM_BRAMS'(1) << k_q[3:0];
      end
      S_LOAD: begin
        ld_if_s = '1;
        clr_s   = '1;
      end
      S_MAC:    psum_s = '1;
      S_DRAIN: begin
        dsel_d = {1'b0, j_q};
        if (!tif.stall) out_s = NUM_BRAMS'(1) << j_q;
      end
      S_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default:  busy_s = 1'b0;
    endcase
  end

  assign tif.w_re           = w_re_s;
  assign tif.if_re          = if_re_s;
  assign tif.ifmap_sel      = sel_d;
  assign tif.en_weight_load = ld_w_s;
  assign tif.en_ifmap_load  = ld_if_s;
  assign tif.en_psum        = psum_s;
  assign tif.clear_psum     = clr_s;
  assign tif.en_output      = out_s;
  assign tif.ifmap_sel_ctrl = '0;
  assign tif.done_select    = dsel_d;
  assign tif.busy           = busy_s;
  assign tif.done           = done_s;

  // Every lane sees the same read address
  for (genvar g = 0; g < NUM_BRAMS; g++) begin : g_lane
    assign tif.w_addr_rd_flat[g*W_ADDR_W +: W_ADDR_W]  = w_addr_d;
    assign tif.if_addr_rd_flat[g*I_ADDR_W +: I_ADDR_W] = if_addr_d;
  end

`ifdef TRANSPOSE_SCHED_PERF_EN
  logic [31:0] pbusy_q, pstall_q;

  // Saturating busy / honoured-stall counters, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else if (accept) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      if (busy_s && (pbusy_q != '1))     pbusy_q  <= pbusy_q + 32'd1;
      if (stall_hon && (pstall_q != '1)) pstall_q <= pstall_q + 32'd1;
    end
  end

  assign tif.perf_busy_cycles  = pbusy_q;
  assign tif.perf_stall_cycles = pstall_q;
`else
  logic unused_stall_hon;
  assign unused_stall_hon = stall_hon;
`endif

endmodule

// File: tb/tb_transpose_tile_scheduler.sv
// Directed bench for transpose_tile_scheduler; cycle 0 is the cycle start is sampled.
module tb_transpose_tile_scheduler;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   first_done;

  transpose_tile_scheduler_if tif ();

  transpose_tile_scheduler dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tif.done === 1'b1 && first_done < 0) first_done = cyc;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic run_until_done(input int limit);
    while (first_done < 0 && cyc < limit) tick();
  endtask

  task automatic launch(input logic [13:0] n, input logic [9:0] wb, input logic [9:0] ib);
    tif.num_ifmap = n;
    tif.w_base    = wb;
    tif.if_base   = ib;
    tif.start     = 1'b1;
    cyc           = 0;
    first_done    = -1;
    tick();
    tif.start     = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    first_done = -1;
    rst   = 1'b1;
    tif.start = 1'b1;
    tif.num_ifmap = 14'd3;
    tif.w_base = 10'd7;
    tif.if_base = 10'd9;
    tif.stall = 1'b0;

    // Reset held for 3 cycles with start asserted
    tick(); tick(); tick();
    chk("rst_busy", tif.busy, 0);
    chk("rst_done", tif.done, 0);
    chk("rst_w_re", tif.w_re, 0);
    chk("rst_en_output", tif.en_output, 0);
    chk("rst_w_addr", tif.w_addr_rd_flat, 0);
    chk("rst_done_select", tif.done_select, 0);
    rst = 1'b0;
    tif.start = 1'b0;
    tick();
    chk("post_rst_busy", tif.busy, 0);

    // N=1, w_base=5, if_base=2
    launch(14'd1, 10'd5, 10'd2);
    chk("n1_c1_w_re", tif.w_re, 16'hFFFF);
    chk("n1_c1_w_addr", tif.w_addr_rd_flat, {16{10'd5}});
    chk("n1_c1_busy", tif.busy, 1);
    tick();
    chk("n1_c2_wload", tif.en_weight_load, 16'hFFFF);
    chk("n1_c2_w_re", tif.w_re, 0);
    tick();
    chk("n1_c3_if_re", tif.if_re, 16'h0001);
    chk("n1_c3_if_addr", tif.if_addr_rd_flat, {16{10'd2}});
    chk("n1_c3_sel", tif.ifmap_sel, 0);
    tick();
    chk("n1_c4_ifload", tif.en_ifmap_load, 16'hFFFF);
    chk("n1_c4_clear", tif.clear_psum, 16'hFFFF);
    tick();
    chk("n1_c5_psum", tif.en_psum, 16'hFFFF);
    chk("n1_c5_ifload", tif.en_ifmap_load, 0);
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("n1_drain_dsel", tif.done_select, 5'(j));
      chk("n1_drain_enout", tif.en_output, 16'h0001 << j);
    end
    tick();
    chk("n1_done_cycle", 32'(first_done), 22);
    chk("n1_c22_busy", tif.busy, 0);
    chk("n1_c22_enout", tif.en_output, 0);
    chk("n1_ctrl_tied", tif.ifmap_sel_ctrl, 0);
    tick();
    chk("n1_c23_done", tif.done, 0);
    chk("n1_hold_w_addr", tif.w_addr_rd_flat, {16{10'd5}});
    chk("n1_hold_dsel", tif.done_select, 15);
    chk("n1_hold_if_addr", tif.if_addr_rd_flat, {16{10'd2}});

    // N=18, if_base=1023: bank wrap and address wrap
    launch(14'd18, 10'd3, 10'd1023);
    run_to(288);
    chk("n18_k15_if_re", tif.if_re, 16'h8000);
    chk("n18_k15_addr", tif.if_addr_rd_flat, {16{10'd1023}});
    run_to(307);
    chk("n18_k16_sel", tif.ifmap_sel, 0);
    chk("n18_k16_if_re", tif.if_re, 16'h0001);
    chk("n18_k16_addr", tif.if_addr_rd_flat, {16{10'd0}});
    run_to(326);
    chk("n18_k17_if_re", tif.if_re, 16'h0002);
    chk("n18_k17_sel", tif.ifmap_sel, 1);
    run_until_done(400);
    chk("n18_done_cycle", 32'(first_done), 345);
    tick();

    // N=0: immediate done, nothing issued
    launch(14'd0, 10'd11, 10'd12);
    chk("n0_done", tif.done, 1);
    chk("n0_busy", tif.busy, 0);
    chk("n0_w_re", tif.w_re, 0);
    chk("n0_if_re", tif.if_re, 0);
    tick();
    chk("n0_c2_done", tif.done, 0);
    chk("n0_c2_busy", tif.busy, 0);

    // N=1 with stall for 4 cycles entering drain beat 7
    launch(14'd1, 10'd1, 10'd4);
    run_to(13);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      tif.stall = 1'b1;
      #1;
      chk("stall_dsel", tif.done_select, 7);
      chk("stall_enout", tif.en_output, 0);
    end
    tick();
    tif.stall = 1'b0;
    #1;
    chk("stall_resume_enout", tif.en_output, 16'h0080);
    chk("stall_resume_dsel", tif.done_select, 7);
    run_until_done(60);
    chk("stall_done_cycle", 32'(first_done), 26);
`ifdef TRANSPOSE_SCHED_PERF_EN
    chk("stall_perf_stall", tif.perf_stall_cycles, 4);
    chk("stall_perf_busy", tif.perf_busy_cycles, 25);
`endif
    tick();

    // N=2 with a second start during busy that must be ignored
    launch(14'd2, 10'd6, 10'd8);
    run_to(10);
    tif.start = 1'b1;
    tif.num_ifmap = 14'd5;
    tif.w_base = 10'd9;
    tick();
    tif.start = 1'b0;
    chk("restart_busy", tif.busy, 1);
    run_to(22);
    chk("restart_k1_if_re", tif.if_re, 16'h0002);
    chk("restart_k1_addr", tif.if_addr_rd_flat, {16{10'd8}});
    run_until_done(80);
    chk("restart_done_cycle", 32'(first_done), 41);
`ifdef TRANSPOSE_SCHED_PERF_EN
    chk("restart_perf_busy", tif.perf_busy_cycles, 40);
    chk("restart_perf_stall", tif.perf_stall_cycles, 0);
    tick();
    chk("restart_perf_hold", tif.perf_busy_cycles, 40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/transpose_tile_scheduler.md
Name: transpose_tile_scheduler

Overview:
Sequencer for the transpose-convolution compute tile (weight BRAM bank, ifmap BRAM bank with 16:1 select, 16-column transpose engine, accumulation/output BRAM).
- Per start: fetches and loads one weight row into all columns.
- Then streams N ifmap elements, each fetch → load/clear → MAC → 16-beat column drain via done_select/en_output.
- Replaces the external per-signal stimulus currently driving the tile's control inputs.

Parameters:
NUM_BRAMS, 16, lane/column count (must be 16; ifmap_sel is 4 bits)
W_ADDR_W, 10, weight BRAM read-address width
I_ADDR_W, 10, ifmap BRAM read-address width
CNT_W, 14, width of num_ifmap (I_ADDR_W+4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle tile start; ignored while busy
num_ifmap  in  CNT_W  ifmap elements N in tile; latched at start
w_base  in  W_ADDR_W  weight row address; latched at start
if_base  in  I_ADDR_W  ifmap base address; latched at start
stall  in  1  downstream backpressure (see Behaviour)
w_re  out  NUM_BRAMS  weight read enables
w_addr_rd_flat  out  NUM_BRAMS*W_ADDR_W  weight read addresses (same value every lane)
if_re  out  NUM_BRAMS  ifmap read enable, one-hot
if_addr_rd_flat  out  NUM_BRAMS*I_ADDR_W  ifmap read addresses (same value every lane)
ifmap_sel  out  4  ifmap bank select
en_weight_load  out  NUM_BRAMS  weight register load
en_ifmap_load  out  NUM_BRAMS  ifmap register load
en_psum  out  NUM_BRAMS  MAC enable
clear_psum  out  NUM_BRAMS  psum clear
en_output  out  NUM_BRAMS  column output strobe, one-hot
ifmap_sel_ctrl  out  NUM_BRAMS  tied 0
done_select  out  5  column drain mux select
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle tile-complete pulse

Behaviour:
- Reset: all outputs 0.
  - State IDLE; counters k=0, j=0; latched config 0.
  - Reset mid-tile aborts immediately; no done pulse.
- States: IDLE, WFETCH, WLOAD, FETCH, LOAD, MAC, DRAIN, DONE.
- IDLE: start=1 latches config.
  - N=0 → DONE.
  - Otherwise → WFETCH.
- WFETCH: w_re=all 1, every lane address = w_base → WLOAD.
- WLOAD: en_weight_load=all 1 → FETCH with k=0.
- FETCH: ifmap_sel=k[3:0]; if_re=1<<k[3:0]; lane address = (if_base + (k>>4)) mod 2^I_ADDR_W (wraps silently) → LOAD.
- LOAD: en_ifmap_load=all 1, clear_psum=all 1 → MAC.
- MAC: en_psum=all 1 → DRAIN with j=0.
- DRAIN (16 beats): done_select=j, en_output=1<<j.
  - j=15: if k==N-1 → DONE, else k++ and → FETCH.
  - Otherwise j++.
- DONE: done=1, busy=0 → IDLE.
- Strobes (w_re, if_re, en_*, clear_psum) are 1 only in their state; 0 elsewhere.
- Addresses, ifmap_sel and done_select hold their last value outside their states.
- Timing for start sampled at cycle 0, N>0:
  - WFETCH at cycle 1, WLOAD at cycle 2.
  - Element k occupies cycles 3+19k .. 21+19k.
  - done at cycle 3+19N.
- Timing for N=0: done at cycle 1; no reads issued.
- busy=1 in every state except IDLE and DONE.
- stall is honoured only in WFETCH, FETCH and DRAIN. There, stall=1 holds state and counters, forces all strobes 0, and holds addresses/selects. The stalled action issues on the first cycle stall=0.
- stall is ignored in WLOAD, LOAD and MAC, keeping the BRAM-to-register hop exactly 1 cycle.
- start during busy: ignored, config unchanged.
- start and stall asserted together in IDLE: start accepted.

Optional Feature:
Macro TRANSPOSE_SCHED_PERF_EN.
- Defined: adds outputs perf_busy_cycles[31:0] and perf_stall_cycles[31:0].
  - Both clear on accepted start, saturate at 2^32-1, hold after done.
  - busy counter counts busy cycles; stall counter counts honoured-stall cycles.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst=1 for 3 cycles with start=1 → all outputs 0, busy=0, no done.
- N=1, w_base=5, if_base=2, no stall:
  - cycle 1: w_re=16'hFFFF, address 5.
  - cycle 3: if_re=16'h0001, address 2, ifmap_sel=0.
  - cycles 6..21: done_select 0..15, en_output 1<<j.
  - done at 22.
- N=18, if_base=1023: element 16 → ifmap_sel=0, address 0 (wrap); element 17 → if_re=16'h0002; done at cycle 345.
- N=0 → done at cycle 1, busy never 1, no strobes.
- N=1, stall=1 for 4 cycles entering DRAIN j=7 → done_select holds 7, en_output=0 for 4 cycles, then 16'h0080; done at 26.
- start pulsed again at cycle 10 of an N=2 tile → ignored, done only at 41. With PERF_EN: perf_busy_cycles=40.
